// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: synchronises PLL lock, sequences downstream reset release, tracks lock losses
module pll_lock_sequencer #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 1024,
  parameter int HOLD_CYCLES   = 16,
  parameter int COUNT_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pll_locked,
  input  logic                   clear_status,
  output logic                   sys_rst,
  output logic                   ready,
  output logic                   lost_lock,
  output logic [COUNT_WIDTH-1:0] loss_count,
  output logic [1:0]             seq_state
);
  localparam int CW = $clog2(STABLE_CYCLES > HOLD_CYCLES ? STABLE_CYCLES : HOLD_CYCLES) + 1;
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
  typedef enum logic [1:0] {WAIT_LOCK = 2'd0, STABILIZE = 2'd1, HOLD_RST = 2'd2, RUN = 2'd3} state_t;
  state_t state;
  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0] cnt;
  logic lock_s;
  assign lock_s    = sync[SYNC_STAGES-1];
  assign seq_state = state;
  // sys_rst/ready are set alongside each transition so they track the state with no lag
  always_ff @(posedge clk) begin
    if (rst) begin
      sync       <= '0;
      state      <= WAIT_LOCK;
      cnt        <= '0;
      sys_rst    <= 1'b1;
      ready      <= 1'b0;
      lost_lock  <= 1'b0;
      loss_count <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pll_locked};
      if (clear_status) lost_lock <= 1'b0;
      case (state)
        WAIT_LOCK: if (lock_s) begin
          state <= STABILIZE;
          cnt   <= '0;
        end
        STABILIZE: if (!lock_s) begin
          state <= WAIT_LOCK;
          cnt   <= '0;
        end else if (cnt == STABLE_LAST) begin
          state <= HOLD_RST;
          cnt   <= '0;
        end else cnt <= cnt + 1'b1;
        HOLD_RST: if (!lock_s) begin
          state <= WAIT_LOCK;
          cnt   <= '0;
        end else if (cnt == HOLD_LAST) begin
          state   <= RUN;
          cnt     <= '0;
          sys_rst <= 1'b0;
          ready   <= 1'b1;
        end else cnt <= cnt + 1'b1;
        RUN: if (!lock_s) begin
          state      <= WAIT_LOCK;
          cnt        <= '0;
          sys_rst    <= 1'b1;
          ready      <= 1'b0;
          lost_lock  <= 1'b1;
          loss_count <= (&loss_count) ? loss_count : loss_count + 1'b1;
        end
        default: state <= WAIT_LOCK;
      endcase
    end
  end
endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer: scoreboard bench; expectations are queued per edge number and checked at negedge
module tb_pll_lock_sequencer;
  logic clk = 1'b0;
  logic rst, pll_locked, clear_status;
  logic sys_rst, ready, lost_lock;
  logic [7:0] loss_count;
  logic [1:0] seq_state;
  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  typedef struct {int at; int sel; int val; string tag;} exp_t;
  exp_t sb[$];

  pll_lock_sequencer #(.SYNC_STAGES(2), .STABLE_CYCLES(8), .HOLD_CYCLES(4), .COUNT_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .pll_locked(pll_locked), .clear_status(clear_status),
    .sys_rst(sys_rst), .ready(ready), .lost_lock(lost_lock),
    .loss_count(loss_count), .seq_state(seq_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @edge %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] obs(input int sel);
    return sel == 0 ? 32'(seq_state) : sel == 1 ? 32'(sys_rst) : sel == 2 ? 32'(ready) :
           sel == 3 ? 32'(lost_lock) : 32'(loss_count);
  endfunction

  task automatic push(input int at, input int sel, input int val, input string tag);
    sb.push_back('{at, sel, val, tag});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) tick();
  endtask

  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("rst_outside_run", 32'(sys_rst | (seq_state == 2'd3)), 1);
      chk("ready_compl", 32'(ready ^ sys_rst), 1);
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].at == cyc) begin
          chk(sb[i].tag, obs(sb[i].sel), 32'(sb[i].val));
          sb.delete(i);
        end else if (sb[i].at < cyc) begin
          chk({sb[i].tag, "_missed"}, 0, 1);
          sb.delete(i);
        end
      end
    end
  end

  // clean lock sequence with first lock-sampling edge e0
  task automatic exp_seq(input int e0);
    push(e0 + 1, 0, 0, "seq_wait");
    push(e0 + 2, 0, 1, "seq_stab");
    push(e0 + 9, 0, 1, "seq_stab_end");
    push(e0 + 10, 0, 2, "seq_hold");
    push(e0 + 13, 1, 1, "seq_hold_sysrst");
    push(e0 + 14, 0, 3, "seq_run");
    push(e0 + 14, 1, 0, "seq_run_sysrst");
    push(e0 + 14, 2, 1, "seq_run_ready");
  endtask

  task automatic loss_cycle(input int n, input bit clr_same, input bit full);
    int c;
    c = cyc;
    pll_locked = 1'b0;
    if (full) begin
      push(c + 2, 0, 3, "pre_loss_state");
      push(c + 2, 1, 0, "pre_loss_sysrst");
    end
    push(c + 3, 0, 0, "loss_state");
    push(c + 3, 1, 1, "loss_sysrst");
    push(c + 3, 3, 1, "loss_flag");
    push(c + 3, 4, n, "loss_count");
    tick();
    tick();
    clear_status = clr_same;
    tick();
    clear_status = 1'b0;
    pll_locked = 1'b1;
    if (full) push(c + 17, 0, 2, "relock_hold");
    push(c + 18, 0, 3, "relock_run");
    wait_cyc(c + 18);
  endtask

  initial begin
    int c;
    rst = 1'b1;
    pll_locked = 1'b0;
    clear_status = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      push(i, 0, 0, "rst_state");
      push(i, 1, 1, "rst_sysrst");
      push(i, 3, 0, "rst_flag");
      push(i, 4, 0, "rst_count");
    end
    tick(); tick(); tick();
    rst = 1'b0;
    push(6, 0, 0, "nolock_idle");
    wait_cyc(6);
    pll_locked = 1'b1;
    exp_seq(7);
    wait_cyc(21);
    rst = 1'b1;
    pll_locked = 1'b0;
    push(22, 0, 0, "rst2_state");
    tick();
    rst = 1'b0;
    c = cyc;
    pll_locked = 1'b1;
    push(c + 3, 0, 1, "s3_stab");
    push(c + 6, 0, 1, "s3_stab_pre_drop");
    push(c + 7, 0, 0, "s3_stab_drop");
    push(c + 8, 0, 0, "s3_wait");
    push(c + 9, 0, 1, "s3_restab");
    push(c + 16, 0, 1, "s3_restab_end");
    push(c + 17, 0, 2, "s3_hold");
    push(c + 20, 0, 2, "s3_hold_pre_drop");
    push(c + 21, 0, 0, "s3_hold_drop");
    push(c + 22, 0, 0, "s3_wait2");
    push(c + 23, 0, 1, "s3_stab2");
    push(c + 30, 0, 1, "s3_stab2_end");
    push(c + 31, 0, 2, "s3_hold2");
    push(c + 34, 1, 1, "s3_hold2_sysrst");
    push(c + 35, 0, 3, "s3_run");
    push(c + 35, 2, 1, "s3_run_ready");
    push(c + 35, 3, 0, "s3_no_flag");
    push(c + 35, 4, 0, "s3_no_count");
    wait_cyc(c + 4);
    pll_locked = 1'b0;
    wait_cyc(c + 6);
    pll_locked = 1'b1;
    wait_cyc(c + 18);
    pll_locked = 1'b0;
    wait_cyc(c + 20);
    pll_locked = 1'b1;
    wait_cyc(c + 35);
    loss_cycle(1, 1'b0, 1'b1);
    c = cyc;
    clear_status = 1'b1;
    push(c + 1, 3, 0, "clr_flag");
    push(c + 1, 4, 1, "clr_count_kept");
    tick();
    clear_status = 1'b0;
    tick();
    loss_cycle(2, 1'b1, 1'b0);
    loss_cycle(3, 1'b0, 1'b0);
    c = cyc;
    rst = 1'b1;
    push(c + 1, 0, 0, "s6_state");
    push(c + 1, 1, 1, "s6_sysrst");
    push(c + 1, 2, 0, "s6_ready");
    push(c + 1, 3, 0, "s6_flag");
    push(c + 1, 4, 0, "s6_count");
    tick();
    rst = 1'b0;
    exp_seq(c + 2);
    wait_cyc(c + 16);
    for (int i = 1; i <= 300; i++) loss_cycle(i > 255 ? 255 : i, 1'b0, 1'b0);
    tick();
    tick();
    chk("sb_drained", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
